// File: rtl/demux1x2_buf_if.sv
// Handshake bundle for demux1x2_buf: one input stream, two output channels and the
// per-channel delivery counters. The slave modport is the demux's view.
interface demux1x2_buf_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux1x2_buf.sv
// Registered 1-to-2 demultiplexer: each output channel has a one-entry holding register,
// so a stalled channel never blocks the other. Counts deliveries per channel.
module demux1x2_buf #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  demux1x2_buf_if.slave  bus
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q [2];
  state_e           state_d [2];
  logic [WIDTH-1:0] data_q  [2];
  logic [WIDTH-1:0] data_d  [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  logic [1:0] full;
  logic [1:0] out_ready;
  logic [1:0] pop;
  logic [1:0] push_k;
  logic       in_ready;
  logic       push;

  always_comb begin
    out_ready = {bus.out1_ready, bus.out0_ready};
    full      = {state_q[1] == StFull, state_q[0] == StFull};
    pop       = full & out_ready;
    // A full channel can still accept when it is being drained on the same edge.
    in_ready  = ~full[bus.in_sel] | out_ready[bus.in_sel];
    push      = bus.in_valid & in_ready;
    push_k    = {push & bus.in_sel, push & ~bus.in_sel};

    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      cnt_d[k]   = cnt_q[k] + CNT_W'(pop[k]);
      unique case (state_q[k])
        StEmpty: begin
          if (push_k[k]) begin
            state_d[k] = StFull;
            data_d[k]  = bus.in_data;
          end
        end
        StFull: begin
          if (pop[k] && push_k[k]) begin
            data_d[k] = bus.in_data;
          end else if (pop[k]) begin
            state_d[k] = StEmpty;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= StEmpty;
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_data  = data_q[0];
  assign bus.out0_valid = full[0];
  assign bus.out1_data  = data_q[1];
  assign bus.out1_valid = full[1];
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux1x2_buf.sv
// Self-checking bench for demux1x2_buf: a per-channel scoreboard queue is filled on each
// accepted push and drained on each delivery; all outputs are checked every cycle.
module tb_demux1x2_buf;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst;

  demux1x2_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux1x2_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] last0, last1;
  logic [CNT_W-1:0] c0, c1;
  logic             pushed;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    c0    = '0;
    c1    = '0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, then return #1 after
  // the rising edge so the caller can drive the next cycle's inputs.
  task automatic step();
    logic exp_rdy;
    logic v0, v1;
    @(negedge clk);
    v0      = (q0.size() != 0);
    v1      = (q1.size() != 0);
    exp_rdy = (bus.in_sel ? !v1 : !v0) | (bus.in_sel ? bus.out1_ready : bus.out0_ready);
    check_eq("in_ready", bus.in_ready, exp_rdy);
    check_eq("out0_valid", bus.out0_valid, v0);
    check_eq("out1_valid", bus.out1_valid, v1);
    check_eq("out0_data", bus.out0_data, last0);
    check_eq("out1_data", bus.out1_data, last1);
    check_eq("cnt0", bus.cnt0, c0);
    check_eq("cnt1", bus.cnt1, c1);
    if (v0 && bus.out0_ready) begin
      check_eq("deliver0", bus.out0_data, q0.pop_front());
      c0++;
    end
    if (v1 && bus.out1_ready) begin
      check_eq("deliver1", bus.out1_data, q1.pop_front());
      c1++;
    end
    pushed = bus.in_valid & exp_rdy;
    if (pushed) begin
      if (bus.in_sel) begin
        q1.push_back(bus.in_data);
        last1 = bus.in_data;
      end else begin
        q0.push_back(bus.in_data);
        last0 = bus.in_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic sel, output int tries);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = sel;
    tries        = 0;
    do begin
      step();
      tries++;
    end while (!pushed && tries < 20);
    if (!pushed) check_eq("push_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_now();
    check_eq("rst_out0_valid", bus.out0_valid, 0);
    check_eq("rst_out1_valid", bus.out1_valid, 0);
    check_eq("rst_out0_data", bus.out0_data, 0);
    check_eq("rst_out1_data", bus.out1_data, 0);
    check_eq("rst_cnt0", bus.cnt0, 0);
    check_eq("rst_cnt1", bus.cnt1, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
  endtask

  int tries;
  logic [WIDTH-1:0] stream [6] = '{4'h0, 4'hF, 4'hA, 4'h5, 4'hC, 4'h3};

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_sel     = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    model_reset();
    #3;
    check_reset_now();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic steering
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    send(4'h0, 1'b0, tries);
    send(4'hF, 1'b1, tries);
    repeat (2) step();
    check_eq("basic_cnt0", bus.cnt0, 1);
    check_eq("basic_cnt1", bus.cnt1, 1);

    // Backpressure on channel 1
    bus.out1_ready = 1'b0;
    send(4'h5, 1'b1, tries);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h3;
    bus.in_sel   = 1'b1;
    repeat (3) begin
      step();
      check_eq("stall_no_push", pushed, 0);
    end
    bus.out1_ready = 1'b1;
    step();
    check_eq("release_push", pushed, 1);
    bus.in_valid = 1'b0;
    repeat (2) step();
    check_eq("bp_cnt1", bus.cnt1, 3);

    // Independence: channel 1 stalled while channel 0 streams
    bus.out1_ready = 1'b0;
    send(4'hC, 1'b1, tries);
    bus.out0_ready = 1'b1;
    send(4'hA, 1'b0, tries);
    check_eq("indep_tries_a", tries, 1);
    send(4'h5, 1'b0, tries);
    check_eq("indep_tries_5", tries, 1);
    repeat (2) step();
    check_eq("indep_out1_hold", bus.out1_data, 4'hC);
    bus.out1_ready = 1'b1;
    repeat (2) step();

    // Streaming: six back-to-back words on channel 0
    foreach (stream[i]) begin
      send(stream[i], 1'b0, tries);
      check_eq("stream_tries", tries, 1);
    end
    repeat (2) step();

    // Reset mid-operation with channel 0 holding 4'hA
    bus.out0_ready = 1'b0;
    send(4'hA, 1'b0, tries);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Counter wrap: five deliveries on channel 0 give 1,2,3,0,1
    bus.out0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(WIDTH'(i + 1), 1'b0, tries);
      step();
      check_eq("wrap_cnt0", bus.cnt0, (i + 1) % 4);
    end

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_sel     = 1'($urandom_range(0, 1));
      bus.in_data    = WIDTH'($urandom);
      bus.out0_ready = 1'($urandom_range(0, 1));
      bus.out1_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
